// File: rtl/pdm_capture.sv
// PDM microphone capture: divides clk into pdm_clk, samples the synchronized
// PDM stream on pdm_clk falling edges, packs 32 bits per word into the buffer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no capture; didx tracks rd_addr, waiting for start
// S_CAP   | capturing; a buffer write every 32 sample events
// S_DONE  | DEPTH words stored; didx tracks rd_addr, start re-arms
module pdm_capture #(
  parameter int CLK_DIV = 50,
  parameter int DEPTH   = 49152
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        pdm_dat,
  input  logic [15:0] rd_addr,
  output logic        pdm_clk,
  output logic [31:0] din,
  output logic [15:0] didx,
  output logic        RW,
  output logic        busy,
  output logic        done
);

  localparam int            DW         = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [15:0]   WADDR_LAST = 16'(DEPTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CAP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [DW-1:0] div_cnt;
  logic          pdm_s1, pdm_s2;
  logic [30:0]   shreg;
  logic [4:0]    bit_cnt;
  logic [15:0]   waddr;
  logic          last_wr;
  logic          div_wrap;
  logic          sample;

  assign div_wrap = (div_cnt == DIV_LAST);
  assign sample   = div_wrap & pdm_clk;
  assign busy     = (state == S_CAP);
  assign done     = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pdm_s1  <= 1'b0;
      pdm_s2  <= 1'b0;
      div_cnt <= '0;
      pdm_clk <= 1'b0;
    end else begin
      pdm_s1 <= pdm_dat;
      pdm_s2 <= pdm_s1;
      if (div_wrap) begin
        div_cnt <= '0;
        pdm_clk <= ~pdm_clk;
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      din     <= '0;
      didx    <= '0;
      RW      <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
      waddr   <= '0;
      last_wr <= 1'b0;
    end else begin
      RW <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          didx <= rd_addr;
          if (start) begin
            state   <= S_CAP;
            bit_cnt <= '0;
            waddr   <= '0;
            shreg   <= '0;
            last_wr <= 1'b0;
          end
        end
        S_CAP: begin
          // Leave one cycle after the final write so busy/done flip as RW drops.
          if (last_wr) begin
            state   <= S_DONE;
            last_wr <= 1'b0;
          end else if (sample) begin
            shreg <= {shreg[29:0], pdm_s2};
            if (bit_cnt == 5'd31) begin
              din     <= {shreg, pdm_s2};
              didx    <= waddr;
              RW      <= 1'b1;
              bit_cnt <= '0;
              waddr   <= waddr + 16'd1;
              last_wr <= (waddr == WADDR_LAST);
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pdm_capture.sv
// Self-checking bench for pdm_capture with a small DEPTH; bits are queued per
// pdm_clk falling edge and expected words are packed from the same bit list.
module tb_pdm_capture;

  localparam int CLK_DIV = 2;
  localparam int DEPTH   = 4;
  localparam int WR_GAP  = 64 * CLK_DIV;

  logic        clk, rst, start, pdm_dat;
  logic [15:0] rd_addr;
  logic        pdm_clk, RW, busy, done;
  logic [31:0] din;
  logic [15:0] didx;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit          bitq[$];
  logic [31:0] wr_din[$];
  logic [15:0] wr_didx[$];
  int          wr_cyc[$];
  int          done_cyc;
  int          rw_long;
  logic [31:0] exp_w[4];

  pdm_capture #(.CLK_DIV(CLK_DIV), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .pdm_dat(pdm_dat), .rd_addr(rd_addr),
    .pdm_clk(pdm_clk), .din(din), .didx(didx), .RW(RW), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // pdm_dat changes just after each falling pdm_clk edge; it is sampled at the next one
  initial forever begin
    @(negedge pdm_clk);
    #1;
    if (bitq.size() > 0) pdm_dat = bitq.pop_front();
    else pdm_dat = 1'($urandom_range(0, 1));
  end

  initial begin
    logic rw_prev, done_prev;
    rw_prev = 1'b0;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (RW) begin
        wr_din.push_back(din);
        wr_didx.push_back(didx);
        wr_cyc.push_back(cyc);
        if (rw_prev) rw_long++;
      end
      if (done && !done_prev) done_cyc = cyc;
      rw_prev = RW;
      done_prev = done;
    end
  end

  task automatic pulse_start_aligned();
    @(negedge pdm_clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic do_capture(input bit restart_mid, input string tag);
    int n;
    @(negedge clk);
    bitq.delete(); wr_din.delete(); wr_didx.delete(); wr_cyc.delete();
    done_cyc = -1;
    rw_long = 0;
    for (int i = 0; i < DEPTH; i++)
      for (int b = 31; b >= 0; b--) bitq.push_back(exp_w[i][b]);
    pulse_start_aligned();
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after_start: busy=%b done=%b, want busy=1 done=0", tag, busy, done);
    end
    if (restart_mid) begin
      repeat (40) @(negedge pdm_clk);
      #1;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy_after_mid_start: busy=%b, want 1", tag, busy);
      end
    end
    n = 0;
    while (done !== 1'b1 && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_state: done=%b busy=%b, want done=1 busy=0", tag, done, busy);
    end
    checks++;
    if (wr_din.size() != DEPTH) begin
      errors++;
      $display("FAIL %s write_count: got %0d, want %0d", tag, wr_din.size(), DEPTH);
    end
    for (int i = 0; i < DEPTH && i < wr_din.size(); i++) begin
      checks++;
      if (wr_didx[i] !== 16'(i) || wr_din[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL %s write%0d: didx=%h din=%h, want didx=%h din=%h",
                 tag, i, wr_didx[i], wr_din[i], 16'(i), exp_w[i]);
      end
      if (i > 0) begin
        checks++;
        if (wr_cyc[i] - wr_cyc[i-1] != WR_GAP) begin
          errors++;
          $display("FAIL %s write_gap%0d: got %0d cycles, want %0d", tag, i, wr_cyc[i] - wr_cyc[i-1], WR_GAP);
        end
      end
    end
    if (wr_cyc.size() > 0) begin
      checks++;
      if (done_cyc != wr_cyc[wr_cyc.size()-1] + 1) begin
        errors++;
        $display("FAIL %s done_timing: done rose cycle %0d, want %0d", tag, done_cyc, wr_cyc[wr_cyc.size()-1] + 1);
      end
    end
    checks++;
    if (rw_long != 0) begin
      errors++;
      $display("FAIL %s rw_width: %0d multi-cycle RW pulses, want 0", tag, rw_long);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rd_addr = 16'h0; pdm_dat = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({pdm_clk, din, didx, RW, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_values: pdm_clk=%b din=%h didx=%h RW=%b busy=%b done=%b, want all 0",
               pdm_clk, din, didx, RW, busy, done);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk);
      #1;
      checks++;
      if (pdm_clk !== 1'((n / CLK_DIV) % 2)) begin
        errors++;
        $display("FAIL pdm_clk_edge%0d: got %b, want %b", n, pdm_clk, 1'((n / CLK_DIV) % 2));
      end
    end
  endtask

  task automatic test_all_ones();
    for (int i = 0; i < DEPTH; i++) exp_w[i] = 32'hFFFF_FFFF;
    do_capture(1'b0, "ones");
  endtask

  task automatic test_patterns();
    exp_w[0] = 32'hAAAA_AAAA;
    exp_w[1] = 32'h1234_5678;
    exp_w[2] = $urandom;
    exp_w[3] = $urandom;
    do_capture(1'b0, "patterns");
  endtask

  task automatic test_start_ignored();
    for (int i = 0; i < DEPTH; i++) exp_w[i] = $urandom;
    do_capture(1'b1, "mid_start");
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    bitq.delete(); wr_din.delete(); wr_didx.delete(); wr_cyc.delete();
    for (int i = 0; i < 32 * DEPTH; i++) bitq.push_back(1'($urandom_range(0, 1)));
    pulse_start_aligned();
    n = 0;
    while (wr_din.size() < 1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (wr_din.size() != 1) begin
      errors++;
      $display("FAIL rst_mid_first_write: got %0d writes, want 1", wr_din.size());
    end
    repeat (20) @(negedge pdm_clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({pdm_clk, din, didx, RW, busy, done} !== '0) begin
      errors++;
      $display("FAIL rst_mid_values: pdm_clk=%b din=%h didx=%h RW=%b busy=%b done=%b, want all 0",
               pdm_clk, din, didx, RW, busy, done);
    end
    repeat (4) begin
      @(negedge clk);
      checks++;
      if (RW !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_hold: RW=%b busy=%b, want 0 0", RW, busy);
      end
    end
    rst = 1'b0;
    repeat (2 * WR_GAP) @(negedge clk);
    checks++;
    if (wr_din.size() != 1) begin
      errors++;
      $display("FAIL rst_mid_no_partial: got %0d writes, want 1", wr_din.size());
    end
    for (int i = 0; i < DEPTH; i++) exp_w[i] = $urandom;
    do_capture(1'b0, "after_rst");
  endtask

  task automatic test_readout();
    logic [15:0] addrs[4];
    logic [15:0] prev;
    addrs[0] = 16'h0000;
    addrs[1] = 16'h0003;
    addrs[2] = 16'hBFFF;
    addrs[3] = 16'($urandom);
    @(negedge clk);
    rd_addr = 16'h5A5A;
    prev = 16'h5A5A;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rd_addr = addrs[i];
      #1;
      checks++;
      if (didx !== prev) begin
        errors++;
        $display("FAIL readout_hold%0d: didx=%h, want %h", i, didx, prev);
      end
      @(posedge clk);
      #1;
      checks++;
      if (didx !== addrs[i] || RW !== 1'b0 || done !== 1'b1) begin
        errors++;
        $display("FAIL readout%0d: didx=%h RW=%b done=%b, want didx=%h RW=0 done=1",
                 i, didx, RW, done, addrs[i]);
      end
      prev = addrs[i];
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_patterns();
    test_start_ignored();
    test_reset_mid();
    test_readout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
